// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: controller FSM states, ALU op codes and
// writeback source codes. The decoder uses the same op and WB encodings.
package pipeline_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned ALU_OP_W  = 3;
  localparam int unsigned WB_SRC_W  = 2;

  // Hazard/sequencing controller states
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MULDIV = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

  // Execute-stage ALU operations
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_DIV = 3'd3,
    ALU_BNE = 3'd4,
    ALU_BEQ = 3'd5,
    ALU_BLT = 3'd6,
    ALU_BGT = 3'd7
  } alu_op_e;

  // Writeback data source
  typedef enum logic [WB_SRC_W-1:0] {
    WB_ALU    = 2'd0,
    WB_MEM    = 2'd1,
    WB_PCNEXT = 2'd2
  } wb_src_e;

  // True for the ops that occupy execute for more than the nominal cycle
  function automatic logic is_muldiv(input logic [ALU_OP_W-1:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard comparator: flags a decode-stage instruction that reads
// the destination of a load currently in execute. Purely combinational so
// a forwarding unit can reuse the same comparison.
//   id_*        decode-stage register usage
//   ex_*        execute-stage writeback info
//   load_use_c  hazard present this cycle
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ex_valid,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_wb_we,
  input  logic [WB_SRC_W-1:0]  ex_wb_src,
  output logic                 load_use_c
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never blocks a reader
  always_comb begin
    ex_is_load = ex_valid && ex_wb_we && (ex_wb_src == WB_MEM) && (ex_rd != '0);
    rs1_hit    = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit    = id_uses_rs2 && (id_rs2 == ex_rd);
    load_use_c = ex_is_load && id_valid && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage integer core.
// Sequences multi-cycle MUL/DIV, resolves load-use hazards, squashes the
// wrong path on redirects and halts the core on EBREAK.
//   _clk, _rst            clock, synchronous active-high reset
//   _id_*                 decode-stage register usage
//   _ex_*                 execute-stage control
//   stall_if_/id_/ex_     per-stage hold
//   flush_id_/ex_         per-stage bubble insertion
//   muldiv_done_          last cycle of a MUL/DIV, result valid
//   halted_               core halted by EBREAK
// Outputs are combinational from state, counter and current inputs.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 16,
  parameter int unsigned CNT_W   = $clog2(DIV_LAT + 1)
) (
  input  logic                 _clk,
  input  logic                 _rst,
  input  logic                 _id_valid,
  input  logic [REG_IDX_W-1:0] _id_rs1,
  input  logic [REG_IDX_W-1:0] _id_rs2,
  input  logic                 _id_uses_rs1,
  input  logic                 _id_uses_rs2,
  input  logic                 _ex_valid,
  input  logic [REG_IDX_W-1:0] _ex_rd,
  input  logic                 _ex_wb_we,
  input  logic [WB_SRC_W-1:0]  _ex_wb_src,
  input  logic [ALU_OP_W-1:0]  _ex_alu_op,
  input  logic                 _ex_redirect,
  input  logic                 _ex_ebreak,
  output logic                 stall_if_,
  output logic                 stall_id_,
  output logic                 stall_ex_,
  output logic                 flush_id_,
  output logic                 flush_ex_,
  output logic                 muldiv_done_,
  output logic                 halted_
);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             load_use_c;
  logic             muldiv_c;
  logic [CNT_W-1:0] lat_c;

  hazard_detect u_hazard_detect (
    .id_valid    (_id_valid),
    .id_rs1      (_id_rs1),
    .id_rs2      (_id_rs2),
    .id_uses_rs1 (_id_uses_rs1),
    .id_uses_rs2 (_id_uses_rs2),
    .ex_valid    (_ex_valid),
    .ex_rd       (_ex_rd),
    .ex_wb_we    (_ex_wb_we),
    .ex_wb_src   (_ex_wb_src),
    .load_use_c  (load_use_c)
  );

  // Multi-cycle op detection and its total execute occupancy
  always_comb begin
    muldiv_c = _ex_valid && is_muldiv(_ex_alu_op);
    lat_c    = (_ex_alu_op == ALU_MUL) ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
  end

  // State and occupancy counter
  always_ff @(posedge _clk) begin
    if (_rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and stage controls
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_if_    = 1'b0;
    stall_id_    = 1'b0;
    stall_ex_    = 1'b0;
    flush_id_    = 1'b0;
    flush_ex_    = 1'b0;
    muldiv_done_ = 1'b0;
    halted_      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (_ex_valid && _ex_ebreak) begin
          // Squash everything younger than the EBREAK before halting
          flush_id_ = 1'b1;
          flush_ex_ = 1'b1;
          state_d   = ST_HALT;
        end else if (muldiv_c && (lat_c > CNT_W'(1))) begin
          // First occupancy cycle; cnt holds the cycles still to come
          stall_if_ = 1'b1;
          stall_id_ = 1'b1;
          stall_ex_ = 1'b1;
          cnt_d     = lat_c - CNT_W'(1);
          state_d   = ST_MULDIV;
        end else if (muldiv_c) begin
          muldiv_done_ = 1'b1;
        end else if (_ex_valid && _ex_redirect) begin
          // Younger instruction is wrong-path, so its load-use is moot
          flush_id_ = 1'b1;
          flush_ex_ = 1'b1;
        end else if (load_use_c) begin
          // Hold the reader in decode and send a bubble into execute
          stall_if_ = 1'b1;
          stall_id_ = 1'b1;
          flush_ex_ = 1'b1;
        end
      end

      ST_MULDIV: begin
        if (cnt_q > CNT_W'(1)) begin
          stall_if_ = 1'b1;
          stall_id_ = 1'b1;
          stall_ex_ = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
        end else begin
          // Execute advances this cycle, so the op is not seen again
          muldiv_done_ = 1'b1;
          cnt_d        = '0;
          state_d      = ST_RUN;
        end
      end

      ST_HALT: begin
        stall_if_ = 1'b1;
        stall_id_ = 1'b1;
        stall_ex_ = 1'b1;
        halted_   = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    // Reset overrides any event, including inputs presented during reset
    if (_rst) begin
      stall_if_    = 1'b0;
      stall_id_    = 1'b0;
      stall_ex_    = 1'b0;
      flush_id_    = 1'b0;
      flush_ex_    = 1'b0;
      muldiv_done_ = 1'b0;
      halted_      = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios with constant
// expectations plus a randomized run against a behavioural model.
// Output vector bit order: {stall_if, stall_id, stall_ex, flush_id,
// flush_ex, muldiv_done, halted}.
module tb_pipeline_ctrl;

  localparam int MUL_CYC = 3;
  localparam int DIV_CYC = 16;

  logic       _clk = 1'b0;
  logic       _rst;
  logic       _id_valid;
  logic [4:0] _id_rs1;
  logic [4:0] _id_rs2;
  logic       _id_uses_rs1;
  logic       _id_uses_rs2;
  logic       _ex_valid;
  logic [4:0] _ex_rd;
  logic       _ex_wb_we;
  logic [1:0] _ex_wb_src;
  logic [2:0] _ex_alu_op;
  logic       _ex_redirect;
  logic       _ex_ebreak;
  logic       stall_if_;
  logic       stall_id_;
  logic       stall_ex_;
  logic       flush_id_;
  logic       flush_ex_;
  logic       muldiv_done_;
  logic       halted_;

  logic [6:0] obs;
  logic [6:0] exp_v;
  int         vectors;
  int         miscompares;

  // Reference model: halted flag and cycles remaining in a long op
  bit         m_halted;
  int         m_left;

  pipeline_ctrl dut (
    ._clk         (_clk),
    ._rst         (_rst),
    ._id_valid    (_id_valid),
    ._id_rs1      (_id_rs1),
    ._id_rs2      (_id_rs2),
    ._id_uses_rs1 (_id_uses_rs1),
    ._id_uses_rs2 (_id_uses_rs2),
    ._ex_valid    (_ex_valid),
    ._ex_rd       (_ex_rd),
    ._ex_wb_we    (_ex_wb_we),
    ._ex_wb_src   (_ex_wb_src),
    ._ex_alu_op   (_ex_alu_op),
    ._ex_redirect (_ex_redirect),
    ._ex_ebreak   (_ex_ebreak),
    .stall_if_    (stall_if_),
    .stall_id_    (stall_id_),
    .stall_ex_    (stall_ex_),
    .flush_id_    (flush_id_),
    .flush_ex_    (flush_ex_),
    .muldiv_done_ (muldiv_done_),
    .halted_      (halted_)
  );

  always #5 _clk = ~_clk;

  assign obs = {stall_if_, stall_id_, stall_ex_, flush_id_, flush_ex_, muldiv_done_, halted_};

  function automatic int op_cycles(input logic [2:0] op);
    if (op == 3'd2) return MUL_CYC;
    if (op == 3'd3) return DIV_CYC;
    return 1;
  endfunction

  function automatic bit model_load_use();
    bit reads5;
    if (!(_ex_valid && _ex_wb_we && _ex_wb_src == 2'd1 && _ex_rd != 5'd0 && _id_valid)) return 0;
    reads5 = (_id_uses_rs1 && _id_rs1 == _ex_rd) || (_id_uses_rs2 && _id_rs2 == _ex_rd);
    return reads5;
  endfunction

  function automatic logic [6:0] model_out();
    int n;
    if (_rst) return 7'b0000000;
    if (m_halted) return 7'b1110001;
    if (m_left > 1) return 7'b1110000;
    if (m_left == 1) return 7'b0000010;
    n = op_cycles(_ex_alu_op);
    if (_ex_valid && _ex_ebreak) return 7'b0001100;
    if (_ex_valid && n > 1) return 7'b1110000;
    if (_ex_valid && (_ex_alu_op == 3'd2 || _ex_alu_op == 3'd3)) return 7'b0000010;
    if (_ex_valid && _ex_redirect) return 7'b0001100;
    if (model_load_use()) return 7'b1100100;
    return 7'b0000000;
  endfunction

  // Advance one clock and the model with it; returns at the next negedge
  task automatic step();
    @(posedge _clk);
    if (_rst) begin
      m_halted = 0;
      m_left   = 0;
    end else if (m_halted) begin
      m_halted = 1;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
    end else if (_ex_valid && _ex_ebreak) begin
      m_halted = 1;
    end else if (_ex_valid && op_cycles(_ex_alu_op) > 1) begin
      m_left = op_cycles(_ex_alu_op) - 1;
    end
    @(negedge _clk);
  endtask

  task automatic idle();
    _rst = 0; _id_valid = 0; _id_rs1 = 0; _id_rs2 = 0; _id_uses_rs1 = 0; _id_uses_rs2 = 0;
    _ex_valid = 0; _ex_rd = 0; _ex_wb_we = 0; _ex_wb_src = 0; _ex_alu_op = 0;
    _ex_redirect = 0; _ex_ebreak = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2);
    _ex_valid = 1; _ex_wb_we = 1; _ex_wb_src = 2'd1; _ex_alu_op = 3'd0; _ex_rd = rd;
    _id_valid = 1; _id_rs1 = rs1; _id_uses_rs1 = u1; _id_rs2 = rs2; _id_uses_rs2 = u2;
  endtask

  task automatic test_reset();
    idle();
    _rst = 1; _ex_valid = 1; _ex_alu_op = 3'd3;
    for (int i = 0; i < 2; i++) begin
      #1; vectors++;
      if (obs !== 7'b0000000) begin
        miscompares++; $display("FAIL reset_hold cyc%0d: got %b want %b", i, obs, 7'b0000000);
      end
      step();
    end
    _rst = 0;
    for (int i = 0; i < DIV_CYC; i++) begin
      exp_v = (i < DIV_CYC - 1) ? 7'b1110000 : 7'b0000010;
      #1; vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL div_after_reset cyc%0d: got %b want %b", i, obs, exp_v);
      end
      step();
    end
    idle();
    #1; vectors++;
    if (obs !== 7'b0000000) begin
      miscompares++; $display("FAIL div_retired: got %b want %b", obs, 7'b0000000);
    end
    step();
  endtask

  task automatic test_mul();
    idle();
    _ex_valid = 1; _ex_alu_op = 3'd2;
    for (int i = 0; i < MUL_CYC; i++) begin
      exp_v = (i < MUL_CYC - 1) ? 7'b1110000 : 7'b0000010;
      #1; vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL mul cyc%0d: got %b want %b", i, obs, exp_v);
      end
      step();
    end
    _ex_alu_op = 3'd0;
    #1; vectors++;
    if (obs !== 7'b0000000) begin
      miscompares++; $display("FAIL mul_back_in_run: got %b want %b", obs, 7'b0000000);
    end
    step();
  endtask

  task automatic test_load_use();
    idle();
    set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    #1; vectors++;
    if (obs !== 7'b1100100) begin
      miscompares++; $display("FAIL load_use_rs1: got %b want %b", obs, 7'b1100100);
    end
    step();
    _ex_valid = 0;
    #1; vectors++;
    if (obs !== 7'b0000000) begin
      miscompares++; $display("FAIL load_use_bubble: got %b want %b", obs, 7'b0000000);
    end
    step();
    set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1; vectors++;
    if (obs !== 7'b0000000) begin
      miscompares++; $display("FAIL load_use_x0: got %b want %b", obs, 7'b0000000);
    end
    step();
    set_load_use(5'd9, 5'd1, 1'b1, 5'd9, 1'b1);
    #1; vectors++;
    if (obs !== 7'b1100100) begin
      miscompares++; $display("FAIL load_use_rs2: got %b want %b", obs, 7'b1100100);
    end
    step();
    set_load_use(5'd9, 5'd9, 1'b0, 5'd9, 1'b0);
    #1; vectors++;
    if (obs !== 7'b0000000) begin
      miscompares++; $display("FAIL load_use_unused_regs: got %b want %b", obs, 7'b0000000);
    end
    step();
    set_load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    _id_valid = 0;
    #1; vectors++;
    if (obs !== 7'b0000000) begin
      miscompares++; $display("FAIL load_use_id_invalid: got %b want %b", obs, 7'b0000000);
    end
    step();
    idle();
  endtask

  task automatic test_redirect_load_use();
    idle();
    set_load_use(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
    _ex_redirect = 1;
    #1; vectors++;
    if (obs !== 7'b0001100) begin
      miscompares++; $display("FAIL redirect_over_load_use: got %b want %b", obs, 7'b0001100);
    end
    step();
    idle();
  endtask

  task automatic test_div_reset();
    idle();
    _ex_valid = 1; _ex_alu_op = 3'd3;
    for (int i = 1; i <= 6; i++) begin
      #1; vectors++;
      if (obs !== 7'b1110000) begin
        miscompares++; $display("FAIL div_pre_reset cyc%0d: got %b want %b", i, obs, 7'b1110000);
      end
      step();
    end
    _rst = 1;
    #1; vectors++;
    if (obs !== 7'b0000000) begin
      miscompares++; $display("FAIL div_reset_cycle: got %b want %b", obs, 7'b0000000);
    end
    step();
    _rst = 0; _ex_alu_op = 3'd0;
    for (int i = 0; i < 3; i++) begin
      #1; vectors++;
      if (obs !== 7'b0000000) begin
        miscompares++; $display("FAIL div_after_reset_run cyc%0d: got %b want %b", i, obs, 7'b0000000);
      end
      step();
    end
    idle();
  endtask

  task automatic test_ebreak();
    idle();
    _ex_valid = 1; _ex_ebreak = 1;
    #1; vectors++;
    if (obs !== 7'b0001100) begin
      miscompares++; $display("FAIL ebreak_flush: got %b want %b", obs, 7'b0001100);
    end
    step();
    for (int i = 0; i < 25; i++) begin
      set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      _ex_redirect = 1'($urandom_range(0, 1));
      _ex_ebreak   = 1'($urandom_range(0, 1));
      _ex_alu_op   = 3'($urandom_range(0, 7));
      #1; vectors++;
      if (obs !== 7'b1110001) begin
        miscompares++; $display("FAIL halt_hold cyc%0d: got %b want %b", i, obs, 7'b1110001);
      end
      step();
    end
    idle();
    _rst = 1;
    #1; vectors++;
    if (obs !== 7'b0000000) begin
      miscompares++; $display("FAIL halt_reset: got %b want %b", obs, 7'b0000000);
    end
    step();
    _rst = 0;
    #1; vectors++;
    if (obs !== 7'b0000000) begin
      miscompares++; $display("FAIL halt_cleared: got %b want %b", obs, 7'b0000000);
    end
    step();
  endtask

  task automatic rand_inputs();
    _rst         = ($urandom_range(0, 59) == 0) || (m_halted && $urandom_range(0, 7) == 0);
    _id_valid    = 1'($urandom_range(0, 3) != 0);
    _id_rs1      = 5'($urandom_range(0, 3));
    _id_rs2      = 5'($urandom_range(0, 3));
    _id_uses_rs1 = 1'($urandom_range(0, 1));
    _id_uses_rs2 = 1'($urandom_range(0, 1));
    _ex_valid    = 1'($urandom_range(0, 3) != 0);
    _ex_rd       = 5'($urandom_range(0, 3));
    _ex_wb_we    = 1'($urandom_range(0, 3) != 0);
    _ex_wb_src   = 2'($urandom_range(0, 2));
    _ex_alu_op   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 3)) : 3'($urandom_range(0, 7));
    if (_ex_alu_op == 3'd2 || _ex_alu_op == 3'd3) _ex_alu_op = ($urandom_range(0, 3) == 0) ? _ex_alu_op : 3'd0;
    _ex_redirect = 1'($urandom_range(0, 4) == 0);
    _ex_ebreak   = 1'($urandom_range(0, 39) == 0);
  endtask

  task automatic test_random();
    idle();
    _rst = 1;
    step();
    for (int i = 0; i < 800; i++) begin
      rand_inputs();
      exp_v = model_out();
      #1; vectors++;
      if (obs !== exp_v) begin
        miscompares++; $display("FAIL random cyc%0d: got %b want %b", i, obs, exp_v);
      end
      step();
    end
    idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_halted    = 0;
    m_left      = 0;
    idle();
    @(negedge _clk);
    test_reset();
    test_mul();
    test_load_use();
    test_redirect_load_use();
    test_div_reset();
    test_ebreak();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
